// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//
// Produces the soft CPU's execute qualifier (CPU_EN) from the board's
// free-run switch and single-step key. It also counts executed instructions
// and can stop at an optional PC breakpoint. Everything runs in the
// FPGA_GlobalClock domain. The CPU advances only on CPU_TICK pulses from the
// clock tree.
//
// Optional feature macro: CPU_RUN_CTRL_BREAKPOINT_EN
//   defined   - PC breakpoint compare, BREAK state and HALTED are built.
//   undefined - match is tied low, BREAK is unreachable, HALTED is 0 and
//               PC_IN/BRK_ADDR/BRK_ARM are ignored.
//
// Parameters
//   DB_BITS  debounce counter width. An input is accepted after
//            2^DB_BITS-1 consecutive cycles of disagreement.
//   CNT_W    width of STEP_COUNT.
//
// Ports
//   FPGA_GlobalClock  in   sole clock
//   NCLR              in   asynchronous active-low reset
//   ALWAYS_CPU_EN     in   raw run switch, active-high, asynchronous
//   ONCE_CPU_EN       in   raw step key, active-low, asynchronous
//   CPU_TICK          in   one-cycle processor-clock tick
//   PC_IN[7:0]        in   current PC of the CPU
//   BRK_ADDR[7:0]     in   breakpoint address
//   BRK_ARM           in   breakpoint enable
//   CPU_EN            out  execute qualifier (combinational from state/match)
//   RUN_STATE[1:0]    out  STOP=00 RUN=01 STEP=10 BREAK=11
//   HALTED            out  1 while in BREAK
//   STEP_COUNT        out  executed-instruction counter (wraps)
// ---------------------------------------------------------------------------
module cpu_run_controller #(
  parameter int DB_BITS = 19,
  parameter int CNT_W   = 16
) (
  input  logic             FPGA_GlobalClock,
  input  logic             NCLR,
  input  logic             ALWAYS_CPU_EN,
  input  logic             ONCE_CPU_EN,
  input  logic             CPU_TICK,
  input  logic [7:0]       PC_IN,
  input  logic [7:0]       BRK_ADDR,
  input  logic             BRK_ARM,
  output logic             CPU_EN,
  output logic [1:0]       RUN_STATE,
  output logic             HALTED,
  output logic [CNT_W-1:0] STEP_COUNT
);

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  // The counter value that becomes all-ones on this cycle's increment.
  localparam logic [DB_BITS-1:0] DB_LAST = {{(DB_BITS-1){1'b1}}, 1'b0};

  logic               run_meta, run_sync;
  logic               key_meta, key_sync;
  logic [DB_BITS-1:0] run_cnt, key_cnt;
  logic               run_lvl;
  logic               key_db, key_db_q;
  logic               step_req;
  logic               match;
  state_t             state;

  // Two-flop synchronizers. The key idles high, so its path resets to 1.
  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge FPGA_GlobalClock or negedge NCLR) begin
    if (!NCLR) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      run_meta <= ALWAYS_CPU_EN;
      run_sync <= run_meta;
      key_meta <= ONCE_CPU_EN;
      key_sync <= key_meta;
    end
  end

  // Debounce. Each counter measures how long the synchronized input has
  // disagreed with its accepted value. Any cycle of agreement, such as a
  // glitch ending, restarts it. When the count reaches all-ones, the new
  // value is accepted and the counter restarts.
  always_ff @(posedge FPGA_GlobalClock or negedge NCLR) begin
    if (!NCLR) begin
      run_cnt  <= '0;
      run_lvl  <= 1'b0;
      key_cnt  <= '0;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
    end else begin
      key_db_q <= key_db;

      if (run_sync == run_lvl) begin
        run_cnt <= '0;
      end else if (run_cnt == DB_LAST) begin
        run_lvl <= run_sync;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + DB_BITS'(1);
      end

      if (key_sync == key_db) begin
        key_cnt <= '0;
      end else if (key_cnt == DB_LAST) begin
        key_db  <= key_sync;
        key_cnt <= '0;
      end else begin
        key_cnt <= key_cnt + DB_BITS'(1);
      end
    end
  end

  // One-cycle request on the accepted press edge (1 -> 0) of the key.
  assign step_req = key_db_q & ~key_db;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign match  = BRK_ARM && (PC_IN == BRK_ADDR);
  assign HALTED = (state == BREAK);
`else
  logic unused_brk;
  assign match      = 1'b0;
  assign HALTED     = 1'b0;
  assign unused_brk = ^{PC_IN, BRK_ADDR, BRK_ARM};
`endif

  // Run/step state machine. A step request that arrives in a state that
  // cannot use it is dropped rather than remembered.
  always_ff @(posedge FPGA_GlobalClock or negedge NCLR) begin
    if (!NCLR) begin
      state <= STOP;
    end else begin
      case (state)
        STOP: begin
          if (run_lvl)       state <= RUN;
          else if (step_req) state <= STEP;
        end
        RUN: begin
          if (!run_lvl)      state <= STOP;
          else if (match)    state <= BREAK;
        end
        STEP: begin
          if (CPU_TICK)      state <= STOP;
        end
        BREAK: begin
          if (step_req)      state <= STEP;
          else if (!run_lvl) state <= STOP;
        end
        default:             state <= STOP;
      endcase
    end
  end

  // The match term gates CPU_EN in the same cycle the PC lands on the
  // breakpoint. The instruction at BRK_ADDR therefore never runs in RUN. It
  // runs only from STEP, which ignores match.
  assign CPU_EN    = ((state == RUN) && !match) || (state == STEP);
  assign RUN_STATE = state;

  always_ff @(posedge FPGA_GlobalClock or negedge NCLR) begin
    if (!NCLR) begin
      STEP_COUNT <= '0;
    end else if (CPU_TICK && CPU_EN) begin
      STEP_COUNT <= STEP_COUNT + CNT_W'(1);
    end
  end

endmodule
